// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: instruction-memory request/response bus plus the decode handoff.
// The fetch unit connects through the master modport; memory and decode connect through the slave modport.
interface ifetch_queue_if;
  // imem: a request issues on any cycle with imem_req && imem_gnt, and imem_addr holds until that cycle
  // (a redirect may change it). Responses return in issue order on imem_rvalid, at least one cycle after
  // issue, with no backpressure. Decode: the head transfers on any cycle with instr_valid && !stall.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] pcplus4;
  logic        instr_valid;

  modport master (
    output imem_req, imem_addr, instr, pcplus4, instr_valid,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr, pcplus4, instr_valid,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: credit-limited imem requests, DEPTH-entry prefetch FIFO, redirect flush.
// Optional macro IFQ_BYPASS_EN: a response arriving at an empty, unstalled queue is presented in the same cycle.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  ifetch_queue_if.master    bus,
  output logic              dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] sh_rd, sh_wr;
  logic [31:0]   fifo_instr  [DEPTH];
  logic [31:0]   fifo_pc4    [DEPTH];
  logic [31:0]   shadow_addr [DEPTH];

  logic          issue, rsp, accept, head_valid, pop, push, bypass;
  logic [CW-1:0] out_next;
  logic [CW:0]   credit_sum;

  // Credits cover in-flight requests plus stored words, so a response always has a free slot.
  assign credit_sum    = {1'b0, outstanding} + {1'b0, count};
  assign bus.imem_req  = !reset && (credit_sum < (CW+1)'(DEPTH));
  assign bus.imem_addr = pc;

  assign issue      = bus.imem_req && bus.imem_gnt;
  assign rsp        = bus.imem_rvalid && (outstanding != '0);
  assign accept     = rsp && (state == RUN) && !bus.redirect;
  assign head_valid = (count != '0);
  assign pop        = head_valid && !bus.stall;
  assign out_next   = outstanding + CW'(issue) - CW'(rsp);

`ifdef IFQ_BYPASS_EN
  assign bypass = accept && !head_valid && !bus.stall;
`else
  assign bypass = 1'b0;
`endif

  assign push      = accept && !bypass;
  assign dbg_state = (state == FLUSH);

  always_comb begin
    bus.instr       = fifo_instr[rd_ptr];
    bus.pcplus4     = fifo_pc4[rd_ptr];
    bus.instr_valid = head_valid;
    if (bypass) begin
      bus.instr       = bus.imem_rdata;
      bus.pcplus4     = shadow_addr[sh_rd] + 32'd4;
      bus.instr_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      sh_rd       <= '0;
      sh_wr       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i]  <= '0;
        fifo_pc4[i]    <= '0;
        shadow_addr[i] <= '0;
      end
    end else begin
      outstanding <= out_next;
      if (issue) pc <= pc + 32'd4;
      // An issue in a redirect cycle belongs to the old stream; it is only counted, never shadowed.
      if (issue && !bus.redirect) begin
        shadow_addr[sh_wr] <= pc;
        sh_wr              <= sh_wr + AW'(1);
      end
      if (accept) sh_rd <= sh_rd + AW'(1);
      if (push) begin
        fifo_instr[wr_ptr] <= bus.imem_rdata;
        fifo_pc4[wr_ptr]   <= shadow_addr[sh_rd] + 32'd4;
        wr_ptr             <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (state == FLUSH && rsp) begin
        discard <= discard - CW'(1);
        if (discard == CW'(1)) state <= RUN;
      end
      // Redirect overrides everything above: every request still in flight after this cycle is stale.
      if (bus.redirect) begin
        pc      <= bus.redirect_pc;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        sh_rd   <= '0;
        sh_wr   <= '0;
        discard <= out_next;
        state   <= (out_next != '0) ? FLUSH : RUN;
      end
    end
  end

  rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (reset)
    bus.imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order variable-latency memory, queue-level reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_ifetch_queue;
  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dbg_state;
  int   checks = 0;
  int   errors = 0;
  int   lat = 1;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 + (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: instr_valid never rose within 40 cycles", name);
    end
  endtask

  // Memory: records issues at the negedge, answers in order lat cycles later.
  initial begin : memory
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    int          cyc;
    cyc = 0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.imem_req && bus.imem_gnt) begin
        mq_addr.push_back(bus.imem_addr);
        mq_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        mq_addr.delete();
        mq_due.delete();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hdead_beef;
      end
    end
  end

  // Reference model: FIFO contents, new-stream in-flight addresses and the stale-response count.
  initial begin : scoreboard
    logic [31:0] exp_q     [$];
    logic [31:0] exp_pc4_q [$];
    logic [31:0] inflight  [$];
    logic [31:0] m_pc, e_i, e_p, a;
    int          m_out, m_discard;
    bit          m_req, m_rsp, byp, e_valid, m_pop;
    m_pc = '0; m_out = 0; m_discard = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete(); exp_pc4_q.delete(); inflight.delete();
        m_pc = 32'h0; m_out = 0; m_discard = 0;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pcplus4", bus.pcplus4, 32'd0);
      end else begin
        m_req = (m_out + exp_q.size()) < DEPTH;
        m_rsp = bus.imem_rvalid && (m_out > 0);
        byp   = BYP && exp_q.size() == 0 && m_rsp && m_discard == 0 && !bus.redirect && !bus.stall;
        e_valid = (exp_q.size() > 0) || byp;
        chk("req", 32'(bus.imem_req), 32'(m_req));
        if (m_req) chk("addr", bus.imem_addr, m_pc);
        chk("valid", 32'(bus.instr_valid), 32'(e_valid));
        if (e_valid) begin
          e_i = byp ? bus.imem_rdata : exp_q[0];
          e_p = byp ? inflight[0] + 32'd4 : exp_pc4_q[0];
          chk("instr", bus.instr, e_i);
          chk("pcplus4", bus.pcplus4, e_p);
        end
        chk("flush_state", 32'(dbg_state), 32'(m_discard > 0));
        m_pop = exp_q.size() > 0 && !bus.stall;
        if (m_pop) begin
          void'(exp_q.pop_front());
          void'(exp_pc4_q.pop_front());
        end
        if (m_rsp) begin
          if (m_discard > 0) m_discard--;
          else if (!bus.redirect) begin
            a = inflight.pop_front();
            if (!byp) begin
              exp_q.push_back(bus.imem_rdata);
              exp_pc4_q.push_back(a + 32'd4);
            end
          end
          m_out--;
        end
        if (m_req && bus.imem_gnt) begin
          if (!bus.redirect) inflight.push_back(m_pc);
          m_pc = m_pc + 32'd4;
          m_out++;
        end
        if (bus.redirect) begin
          exp_q.delete(); exp_pc4_q.delete(); inflight.delete();
          m_pc = bus.redirect_pc;
          m_discard = m_out;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.imem_gnt = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0;
    repeat (3) next();
    reset = 1'b0;
  endtask

  initial begin : driver
    logic [31:0] addrs [$];
    logic [31:0] pops  [$];
    logic [31:0] first_addr;
    logic [31:0] gnt_pat, stall_pat;
    bit          ok, got_req;
    int          n_iss;
    bus.imem_gnt = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

    // Reset held three cycles, then request at RESET_PC
    repeat (3) next();
    chk("t1_req_in_reset", 32'(bus.imem_req), 32'd0);
    chk("t1_valid_in_reset", 32'(bus.instr_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("t1_req_after", 32'(bus.imem_req), 32'd1);
    chk("t1_addr_after", bus.imem_addr, 32'h0);

    // Streaming with a 1-cycle memory
    lat = 1; bus.imem_gnt = 1'b1;
    wait_valid("t2_wait", ok);
    chk("t2_instr0", bus.instr, 32'h2000_0000);
    chk("t2_pc4_0", bus.pcplus4, 32'h4);
    @(negedge clk);
    chk("t2_instr1", bus.instr, 32'h2000_0001);
    chk("t2_pc4_1", bus.pcplus4, 32'h8);
    @(negedge clk);
    chk("t2_instr2", bus.instr, 32'h2000_0002);
    chk("t2_pc4_2", bus.pcplus4, 32'hC);
    next(); bus.imem_gnt = 1'b0;
    repeat (6) next();

    // Fill under stall: exactly DEPTH issues, then req drops; release resumes at 0x10
    do_reset();
    lat = 1; bus.stall = 1'b1; bus.imem_gnt = 1'b1;
    n_iss = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_gnt) begin
        n_iss++;
        addrs.push_back(bus.imem_addr);
      end
    end
    chk("t3_issues", 32'(n_iss), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_addr", (i < addrs.size()) ? addrs[i] : 32'hffff_ffff, 32'(4 * i));
    chk("t3_req_full", 32'(bus.imem_req), 32'd0);
    next(); bus.stall = 1'b0;
    got_req = 1'b0; first_addr = '1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.instr_valid && !bus.stall && pops.size() < 4) pops.push_back(bus.instr);
      if (bus.imem_req && !got_req) begin
        got_req = 1'b1;
        first_addr = bus.imem_addr;
      end
    end
    for (int i = 0; i < 4; i++) chk("t3_pop", (i < pops.size()) ? pops[i] : 32'hffff_ffff, 32'h2000_0000 + 32'(i));
    chk("t3_resume_addr", first_addr, 32'h10);
    next(); bus.imem_gnt = 1'b0;
    repeat (8) next();

    // Redirect with two requests in flight, 3-cycle memory
    do_reset();
    lat = 3; bus.imem_gnt = 1'b1;
    next();
    next(); bus.imem_gnt = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    next(); bus.redirect = 1'b0; bus.imem_gnt = 1'b1;
    #1;
    chk("t4_valid_after", 32'(bus.instr_valid), 32'd0);
    chk("t4_flushing", 32'(dbg_state), 32'd1);
    chk("t4_addr", bus.imem_addr, 32'h40);
    wait_valid("t4_wait", ok);
    chk("t4_pc4", bus.pcplus4, 32'h44);
    chk("t4_instr", bus.instr, 32'h2000_0010);
    next(); bus.imem_gnt = 1'b0;
    repeat (8) next();

    // Redirect in the same cycle as a response and an issue
    do_reset();
    lat = 2; bus.imem_gnt = 1'b1;
    next();
    next(); bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
    #1;
    chk("t5_pre_rvalid", 32'(bus.imem_rvalid), 32'd1);
    chk("t5_pre_req", 32'(bus.imem_req), 32'd1);
    next(); bus.redirect = 1'b0;
    wait_valid("t5_wait", ok);
    chk("t5_pc4", bus.pcplus4, 32'h84);
    chk("t5_instr", bus.instr, 32'h2000_0020);
    next(); bus.imem_gnt = 1'b0;
    repeat (8) next();

    // Mixed table: gaps in grant, stall bursts, a redirect and a second one during the flush
    do_reset();
    lat = 2;
    gnt_pat   = 32'b1111_0111_1101_1111_1110_1111_1011_1111;
    stall_pat = 32'b0000_1100_0011_0000_0111_0000_1100_0110;
    for (int i = 0; i < 32; i++) begin
      bus.imem_gnt    = gnt_pat[i];
      bus.stall       = stall_pat[i];
      bus.redirect    = (i == 6) || (i == 8);
      bus.redirect_pc = (i == 6) ? 32'h200 : 32'h300;
      next();
    end
    bus.imem_gnt = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0;
    repeat (10) next();
    chk("t7_drained", 32'(bus.instr_valid), 32'd0);

    // Head latency: 0 with bypass, 1 otherwise
    do_reset();
    lat = 1; bus.imem_gnt = 1'b1;
    next(); bus.imem_gnt = 1'b0;
    #1;
    chk("t8_rvalid", 32'(bus.imem_rvalid), 32'd1);
    chk("t8_same_cycle", 32'(bus.instr_valid), 32'(BYP));
    next();
    #1;
    chk("t8_next_cycle", 32'(bus.instr_valid), 32'(!BYP));
    repeat (4) next();

    // Asynchronous reset with a valid head and three requests outstanding
    do_reset();
    lat = 4; bus.stall = 1'b1; bus.imem_gnt = 1'b1;
    repeat (4) next();
    bus.imem_gnt = 1'b0;
    next();
    #1;
    chk("t6_pre_valid", 32'(bus.instr_valid), 32'd1);
    chk("t6_pre_instr", bus.instr, 32'h2000_0000);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_req", 32'(bus.imem_req), 32'd0);
    chk("t6_async_valid", 32'(bus.instr_valid), 32'd0);
    chk("t6_async_instr", bus.instr, 32'd0);
    chk("t6_async_pc4", bus.pcplus4, 32'd0);
    repeat (2) next();
    bus.stall = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_addr_after", bus.imem_addr, 32'h0);
    chk("t6_req_after", 32'(bus.imem_req), 32'd1);
    repeat (4) next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
